// File: rtl/uart_cmd_pkg.sv
// Shared types and constants for the UART command/response engine.
// Holds the FSM state encoding plus frame sync, command and status codes.
package uart_cmd_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CMD,
    S_ADDR,
    S_DATA,
    S_CSUM,
    S_EXEC,
    S_WAITRD,
    S_REPLY
  } state_t;

  localparam logic [7:0] SYNC_REQ    = 8'hA5;
  localparam logic [7:0] SYNC_RSP    = 8'h5A;
  localparam logic [7:0] CMD_WR      = 8'h01;
  localparam logic [7:0] CMD_RD      = 8'h02;
  localparam logic [7:0] ST_OK       = 8'h00;
  localparam logic [7:0] ST_BAD_CSUM = 8'h01;
  localparam logic [7:0] ST_BAD_CMD  = 8'h02;

  function automatic logic [7:0] sum8(input logic [7:0] a, input logic [7:0] b,
                                      input logic [7:0] c);
    return a + b + c;
  endfunction

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/uart_cmd_resp.sv
// UART command/response engine: parses 5-byte request frames from the RX FIFO,
// runs one register-bus access and pushes a 4-byte reply into the TX FIFO.
module uart_cmd_resp
  import uart_cmd_pkg::*;
#(
  parameter int ADDR_WIDTH = 8,
  parameter int TIMEOUT    = 8680
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [7:0]            RX_DOUT,
  input  logic [ADDR_WIDTH-1:0] RX_USEDW,
  output logic                  RX_RDREQ,
  output logic [7:0]            TX_DIN,
  output logic                  TX_WRREQ,
  input  logic [ADDR_WIDTH-1:0] TX_USEDW,
  output logic [7:0]            REG_ADDR,
  output logic [7:0]            REG_WDATA,
  output logic                  REG_WE,
  output logic                  REG_RE,
  input  logic [7:0]            REG_RDATA,
  output logic [7:0]            ERR_CNT,
  output logic                  BUSY
);

  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);
  localparam logic [ADDR_WIDTH-1:0] TX_FULL = '1;

  state_t          state_q, state_d;
  logic            rd_req_q, rd_req_d;
  logic            rd_vld_q, rd_vld_d;
  logic [TW-1:0]   tmo_q, tmo_d;
  logic [7:0]      cmd_q, cmd_d;
  logic [7:0]      addr_q, addr_d;
  logic [7:0]      data_q, data_d;
  logic [7:0]      csum_q, csum_d;
  logic [7:0]      status_q, status_d;
  logic [7:0]      rdata_q, rdata_d;
  logic [1:0]      idx_q, idx_d;
  logic            reg_we_q, reg_we_d;
  logic            reg_re_q, reg_re_d;
  logic [7:0]      reg_addr_q, reg_addr_d;
  logic [7:0]      reg_wdata_q, reg_wdata_d;
  logic [7:0]      err_q, err_d;

  logic            fetch_st;
  logic            in_frame;
  logic            tx_wrreq;
  logic [7:0]      tx_din;

  always_comb begin
    state_d     = state_q;
    rd_req_d    = 1'b0;
    rd_vld_d    = rd_req_q;
    tmo_d       = tmo_q;
    cmd_d       = cmd_q;
    addr_d      = addr_q;
    data_d      = data_q;
    csum_d      = csum_q;
    status_d    = status_q;
    rdata_d     = rdata_q;
    idx_d       = idx_q;
    reg_we_d    = 1'b0;
    reg_re_d    = 1'b0;
    reg_addr_d  = reg_addr_q;
    reg_wdata_d = reg_wdata_q;
    err_d       = err_q;
    tx_wrreq    = 1'b0;
    tx_din      = 8'h00;

    fetch_st = (state_q == S_IDLE) || (state_q == S_CMD) || (state_q == S_ADDR) ||
               (state_q == S_DATA) || (state_q == S_CSUM);
    in_frame = fetch_st && (state_q != S_IDLE);

    // One pop in flight at a time: request, wait for data, consume, repeat.
    if (fetch_st && !rd_req_q && !rd_vld_q && (RX_USEDW != '0)) begin
      rd_req_d = 1'b1;
    end

    if (!in_frame || rd_req_d) begin
      tmo_d = '0;
    end else begin
      tmo_d = tmo_q + 1'b1;
    end

    case (state_q)
      S_IDLE: begin
        if (rd_vld_q && (RX_DOUT == SYNC_REQ)) begin
          state_d = S_CMD;
        end
      end

      S_CMD, S_ADDR, S_DATA, S_CSUM: begin
        if (rd_vld_q) begin
          case (state_q)
            S_CMD:   begin cmd_d  = RX_DOUT; state_d = S_ADDR; end
            S_ADDR:  begin addr_d = RX_DOUT; state_d = S_DATA; end
            S_DATA:  begin data_d = RX_DOUT; state_d = S_CSUM; end
            default: begin csum_d = RX_DOUT; state_d = S_EXEC; end
          endcase
        end else if (!rd_req_d && (tmo_q == TMO_LAST)) begin
          state_d = S_IDLE;
          tmo_d   = '0;
          err_d   = sat_inc(err_q);
        end
      end

      S_EXEC: begin
        idx_d = 2'd0;
        if (sum8(cmd_q, addr_q, data_q) != csum_q) begin
          status_d = ST_BAD_CSUM;
          rdata_d  = 8'h00;
          err_d    = sat_inc(err_q);
          state_d  = S_REPLY;
        end else if (cmd_q == CMD_WR) begin
          reg_we_d    = 1'b1;
          reg_addr_d  = addr_q;
          reg_wdata_d = data_q;
          status_d    = ST_OK;
          rdata_d     = data_q;
          state_d     = S_REPLY;
        end else if (cmd_q == CMD_RD) begin
          reg_re_d   = 1'b1;
          reg_addr_d = addr_q;
          state_d    = S_WAITRD;
        end else begin
          status_d = ST_BAD_CMD;
          rdata_d  = 8'h00;
          err_d    = sat_inc(err_q);
          state_d  = S_REPLY;
        end
      end

      S_WAITRD: begin
        // Read data is valid the cycle after the REG_RE pulse.
        if (!reg_re_q) begin
          status_d = ST_OK;
          rdata_d  = REG_RDATA;
          state_d  = S_REPLY;
        end
      end

      S_REPLY: begin
        case (idx_q)
          2'd0:    tx_din = SYNC_RSP;
          2'd1:    tx_din = status_q;
          2'd2:    tx_din = rdata_q;
          default: tx_din = status_q + rdata_q;
        endcase
        if (TX_USEDW != TX_FULL) begin
          tx_wrreq = 1'b1;
          idx_d    = idx_q + 2'd1;
          if (idx_q == 2'd3) begin
            state_d = S_IDLE;
          end
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q     <= S_IDLE;
      rd_req_q    <= 1'b0;
      rd_vld_q    <= 1'b0;
      tmo_q       <= '0;
      cmd_q       <= 8'h00;
      addr_q      <= 8'h00;
      data_q      <= 8'h00;
      csum_q      <= 8'h00;
      status_q    <= 8'h00;
      rdata_q     <= 8'h00;
      idx_q       <= 2'd0;
      reg_we_q    <= 1'b0;
      reg_re_q    <= 1'b0;
      reg_addr_q  <= 8'h00;
      reg_wdata_q <= 8'h00;
      err_q       <= 8'h00;
    end else begin
      state_q     <= state_d;
      rd_req_q    <= rd_req_d;
      rd_vld_q    <= rd_vld_d;
      tmo_q       <= tmo_d;
      cmd_q       <= cmd_d;
      addr_q      <= addr_d;
      data_q      <= data_d;
      csum_q      <= csum_d;
      status_q    <= status_d;
      rdata_q     <= rdata_d;
      idx_q       <= idx_d;
      reg_we_q    <= reg_we_d;
      reg_re_q    <= reg_re_d;
      reg_addr_q  <= reg_addr_d;
      reg_wdata_q <= reg_wdata_d;
      err_q       <= err_d;
    end
  end

  assign RX_RDREQ  = rd_req_q;
  assign TX_WRREQ  = tx_wrreq;
  assign TX_DIN    = tx_din;
  assign REG_WE    = reg_we_q;
  assign REG_RE    = reg_re_q;
  assign REG_ADDR  = reg_addr_q;
  assign REG_WDATA = reg_wdata_q;
  assign ERR_CNT   = err_q;
  assign BUSY      = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_cmd_resp.sv
// Bench for uart_cmd_resp: FIFO and register-file models around the DUT,
// with a reply-byte scoreboard, a vector table and multi-cycle corner sequences.
module tb_uart_cmd_resp;

  localparam int AW  = 8;
  localparam int TMO = 300;

  logic          CLK = 1'b0;
  logic          RST = 1'b1;
  logic [7:0]    RX_DOUT = 8'h00;
  logic [AW-1:0] RX_USEDW = '0;
  logic          RX_RDREQ;
  logic [7:0]    TX_DIN;
  logic          TX_WRREQ;
  logic [AW-1:0] TX_USEDW = '0;
  logic [7:0]    REG_ADDR, REG_WDATA, REG_RDATA = 8'h00, ERR_CNT;
  logic          REG_WE, REG_RE, BUSY;

  uart_cmd_resp #(.ADDR_WIDTH(AW), .TIMEOUT(TMO)) dut (
    .CLK(CLK), .RST(RST),
    .RX_DOUT(RX_DOUT), .RX_USEDW(RX_USEDW), .RX_RDREQ(RX_RDREQ),
    .TX_DIN(TX_DIN), .TX_WRREQ(TX_WRREQ), .TX_USEDW(TX_USEDW),
    .REG_ADDR(REG_ADDR), .REG_WDATA(REG_WDATA), .REG_WE(REG_WE), .REG_RE(REG_RE),
    .REG_RDATA(REG_RDATA), .ERR_CNT(ERR_CNT), .BUSY(BUSY)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  logic [7:0] rx_q[$];
  logic [7:0] exp_q[$];
  logic [7:0] mem[256];
  bit         rdreq_s, re_s, tx_full;
  logic [7:0] re_addr, last_wa, last_wd;
  int         we_cnt, re_cnt, tx_cnt, full_push, underflow;

  // Strobes sampled mid-cycle; they take effect at the following rising edge.
  always @(negedge CLK) begin
    rdreq_s = RX_RDREQ;
    re_s    = REG_RE;
    re_addr = REG_ADDR;
    if (REG_WE) begin
      mem[REG_ADDR] = REG_WDATA;
      last_wa = REG_ADDR;
      last_wd = REG_WDATA;
      we_cnt++;
    end
    if (REG_RE) re_cnt++;
    if (TX_WRREQ) begin
      tx_cnt++;
      if (tx_full) full_push++;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL tx_unexpected actual=%0h required=none", TX_DIN);
      end else begin
        check("tx_byte", {24'h0, TX_DIN}, {24'h0, exp_q.pop_front()});
      end
    end
  end

  always @(posedge CLK) begin
    if (rdreq_s) begin
      if (rx_q.size() > 0) RX_DOUT <= rx_q.pop_front();
      else underflow++;
    end
    if (re_s) REG_RDATA <= mem[re_addr];
    RX_USEDW <= AW'(rx_q.size());
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge CLK);
      #1;
    end
  endtask

  task automatic set_full(input bit f);
    tx_full  = f;
    TX_USEDW = f ? '1 : '0;
  endtask

  task automatic push_frame(input logic [55:0] bytes, input int n);
    for (int k = 0; k < n; k++) rx_q.push_back(bytes[55-8*k -: 8]);
  endtask

  task automatic expect_reply(input logic [31:0] rep);
    for (int k = 0; k < 4; k++) exp_q.push_back(rep[31-8*k -: 8]);
  endtask

  task automatic wait_done(input string name);
    int n = 0;
    while ((rx_q.size() != 0 || exp_q.size() != 0 || BUSY) && n < 3000) begin
      tick(1);
      n++;
    end
    check(name, n < 3000, 1);
    tick(3);
  endtask

  typedef struct {
    int          n;
    logic [55:0] bytes;
    logic [31:0] rep;
    int          we;
    int          re;
    logic [7:0]  wa;
    logic [7:0]  wd;
    logic [7:0]  err;
  } vec_t;

  vec_t vt[6];

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    int w0, r0, t0, n;

    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    mem[8'h22] = 8'h99;
    set_full(1'b0);

    vt[0] = '{5, 56'hA5_01_10_3C_4D_00_00, 32'h5A_00_3C_3C, 1, 0, 8'h10, 8'h3C, 8'd0};
    vt[1] = '{5, 56'hA5_02_22_00_24_00_00, 32'h5A_00_99_99, 0, 1, 8'h00, 8'h00, 8'd0};
    vt[2] = '{7, 56'h00_FF_A5_01_10_3C_4E, 32'h5A_01_00_01, 0, 0, 8'h00, 8'h00, 8'd1};
    vt[3] = '{5, 56'hA5_07_00_00_07_00_00, 32'h5A_02_00_02, 0, 0, 8'h00, 8'h00, 8'd2};
    vt[4] = '{5, 56'hA5_01_A5_11_B7_00_00, 32'h5A_00_11_11, 1, 0, 8'hA5, 8'h11, 8'd2};
    vt[5] = '{5, 56'hA5_02_A5_00_A7_00_00, 32'h5A_00_11_11, 0, 1, 8'h00, 8'h00, 8'd2};

    tick(3);
    check("reset_outputs",
          {RX_RDREQ, TX_WRREQ, REG_WE, REG_RE, BUSY, TX_DIN, REG_ADDR, REG_WDATA, ERR_CNT}, 0);
    RST = 1'b0;
    tick(3);

    for (int i = 0; i < 6; i++) begin
      w0 = we_cnt;
      r0 = re_cnt;
      expect_reply(vt[i].rep);
      push_frame(vt[i].bytes, vt[i].n);
      wait_done($sformatf("vec%0d_done", i));
      check($sformatf("vec%0d_we", i), we_cnt - w0, vt[i].we);
      check($sformatf("vec%0d_re", i), re_cnt - r0, vt[i].re);
      check($sformatf("vec%0d_err", i), ERR_CNT, vt[i].err);
      if (vt[i].we != 0) check($sformatf("vec%0d_wr", i), {last_wa, last_wd}, {vt[i].wa, vt[i].wd});
    end

    // Inter-byte timeout drops a partial frame, then a read succeeds.
    t0 = tx_cnt;
    push_frame(56'hA5_01_00_00_00_00_00, 2);
    n = 0;
    while (rx_q.size() != 0 && n < 100) begin tick(1); n++; end
    check("tmo_fetch", n < 100, 1);
    tick(TMO - 20);
    check("tmo_still_busy", BUSY, 1);
    tick(40);
    check("tmo_idle", BUSY, 0);
    check("tmo_err", ERR_CNT, 3);
    check("tmo_no_reply", tx_cnt - t0, 0);
    r0 = re_cnt;
    expect_reply(32'h5A_00_99_99);
    push_frame(56'hA5_02_22_00_24_00_00, 5);
    wait_done("tmo_read_done");
    check("tmo_read_re", re_cnt - r0, 1);

    // TX FIFO full for 100 cycles mid-reply; a new request waits in the RX FIFO.
    t0 = tx_cnt;
    w0 = we_cnt;
    set_full(1'b1);
    expect_reply(32'h5A_00_55_55);
    push_frame(56'hA5_01_20_55_76_00_00, 5);
    n = 0;
    while (we_cnt == w0 && n < 200) begin tick(1); n++; end
    check("stall_we_seen", n < 200, 1);
    expect_reply(32'h5A_00_99_99);
    push_frame(56'hA5_02_22_00_24_00_00, 5);
    tick(100);
    check("stall_rx_untouched", rx_q.size(), 5);
    check("stall_no_tx", tx_cnt - t0, 0);
    check("stall_busy", BUSY, 1);
    set_full(1'b0);
    wait_done("stall_done");
    check("stall_tx_count", tx_cnt - t0, 8);
    check("stall_full_push", full_push, 0);
    check("stall_wr", {last_wa, last_wd}, 16'h20_55);

    // Reset pulsed while the reply is stalled.
    r0 = re_cnt;
    set_full(1'b1);
    push_frame(56'hA5_02_22_00_24_00_00, 5);
    n = 0;
    while (re_cnt == r0 && n < 200) begin tick(1); n++; end
    check("rst_re_seen", n < 200, 1);
    tick(5);
    check("rst_pre_busy", BUSY, 1);
    RST = 1'b1;
    #2;
    check("rst_async_outputs",
          {RX_RDREQ, TX_WRREQ, REG_WE, REG_RE, BUSY, TX_DIN, REG_ADDR, REG_WDATA, ERR_CNT}, 0);
    set_full(1'b0);
    tick(2);
    RST = 1'b0;
    tick(3);
    check("rst_idle", {BUSY, ERR_CNT}, 0);

    // Reset mid-frame, then the block must hunt for sync afresh.
    push_frame(56'hA5_01_00_00_00_00_00, 2);
    n = 0;
    while (rx_q.size() != 0 && n < 100) begin tick(1); n++; end
    tick(3);
    RST = 1'b1;
    tick(2);
    RST = 1'b0;
    tick(2);
    w0 = we_cnt;
    t0 = tx_cnt;
    expect_reply(32'h5A_00_3C_3C);
    push_frame(56'h10_3C_A5_01_10_3C_4D, 7);
    wait_done("post_rst_done");
    check("post_rst_we", we_cnt - w0, 1);
    check("post_rst_tx", tx_cnt - t0, 4);
    check("post_rst_err", ERR_CNT, 0);
    check("rx_underflow", underflow, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
